// File: rtl/stack_mem_arbiter.sv
// stack_mem_arbiter: shares the data memory's single port between the
// pipeline MEM stage and the stack unit. It owns the stack pointer and
// splits 32-bit stack transfers into two sequential 16-bit accesses.
module stack_mem_arbiter #(
  parameter int SP_INIT     = 2047,
  parameter int STACK_LIMIT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // pipeline MEM stage port
  input  logic        i_p_req,
  input  logic        i_p_we,
  input  logic [31:0] i_p_addr,
  input  logic [15:0] i_p_wdata,
  output logic        o_p_ack,
  output logic [15:0] o_p_rdata,
  output logic        o_p_stall,
  // stack unit port
  input  logic        i_s_req,
  input  logic [1:0]  i_s_op,
  input  logic [31:0] i_s_wdata,
  output logic        o_s_ack,
  output logic        o_s_err,
  output logic [31:0] o_s_rdata,
  output logic [10:0] o_sp,
  // data memory port
  output logic        o_mem_cs,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    P_ACC = 2'd1,
    S_W0  = 2'd2,
    S_W1  = 2'd3
  } state_t;

  // Bounds are compared in 12 bits so sp+1 / sp-1 style limits cannot wrap.
  localparam logic [10:0] SP_RST     = 11'(SP_INIT);
  localparam logic [11:0] PUSH16_MIN = 12'(STACK_LIMIT);
  localparam logic [11:0] PUSH32_MIN = 12'(STACK_LIMIT + 1);
  localparam logic [11:0] POP16_MAX  = 12'(SP_INIT - 1);
  localparam logic [11:0] POP32_MAX  = 12'(SP_INIT - 2);

  state_t      r_state;
  logic        r_last_grant_s;   // 1 = stack was granted last, 0 = pipeline
  logic [10:0] r_sp;
  logic [1:0]  r_s_op;
  logic [31:0] r_s_wdata;
  logic        r_p_we;
  logic [31:0] r_p_addr;
  logic [15:0] r_p_wdata;
  logic        r_p_ack;
  logic [15:0] r_p_rdata;
  logic        r_s_ack;
  logic        r_s_err;
  logic [31:0] r_s_rdata;
  logic [15:0] r_pop_lo;         // low half of a pop32, held until the high half arrives

  logic        w_p_cand;
  logic        w_s_cand;
  logic        w_grant_p;
  logic        w_grant_s;
  logic        w_s_bad;
  logic [11:0] w_sp12;
  logic        w_is_pop;
  logic        w_is_32;
  logic [10:0] w_stk_addr;

  // A port that is acknowledging this cycle must not win a new grant yet.
  assign w_p_cand  = i_p_req && !r_p_ack;
  assign w_s_cand  = i_s_req && !r_s_ack;
  assign w_grant_s = (r_state == IDLE) && w_s_cand && (!w_p_cand || !r_last_grant_s);
  assign w_grant_p = (r_state == IDLE) && w_p_cand && !w_grant_s;

  assign w_sp12   = {1'b0, r_sp};
  assign w_is_pop = r_s_op[0];
  assign w_is_32  = r_s_op[1];

  // Overflow/underflow check on the requested stack op, evaluated at grant.
  always_comb begin
    w_s_bad = 1'b0;
    case (i_s_op)
      2'b00:   w_s_bad = (w_sp12 < PUSH16_MIN);
      2'b01:   w_s_bad = (w_sp12 > POP16_MAX);
      2'b10:   w_s_bad = (w_sp12 < PUSH32_MIN);
      default: w_s_bad = (w_sp12 > POP32_MAX);
    endcase
  end

  // Stack word address: pushes work downward from sp, pops upward from sp+1.
  always_comb begin
    w_stk_addr = r_sp;
    if (w_is_pop) begin
      w_stk_addr = (r_state == S_W1) ? (r_sp + 11'd2) : (r_sp + 11'd1);
    end else begin
      w_stk_addr = (r_state == S_W1) ? (r_sp - 11'd1) : r_sp;
    end
  end

  // Memory pins decoded from state and the latched request fields.
  always_comb begin
    o_mem_cs    = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_addr  = 32'd0;
    o_mem_wdata = 16'd0;
    case (r_state)
      P_ACC: begin
        o_mem_cs    = 1'b1;
        o_mem_read  = !r_p_we;
        o_mem_write = r_p_we;
        o_mem_addr  = r_p_addr;
        o_mem_wdata = r_p_wdata;
      end
      S_W0, S_W1: begin
        o_mem_cs    = 1'b1;
        o_mem_read  = w_is_pop;
        o_mem_write = !w_is_pop;
        o_mem_addr  = {21'd0, w_stk_addr};
        // push32 writes the high half first (at sp), then the low half
        o_mem_wdata = (w_is_32 && (r_state == S_W0)) ? r_s_wdata[31:16] : r_s_wdata[15:0];
      end
      default: ;
    endcase
  end

  // Main sequencer: arbitration, access sequencing, sp update and acks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_last_grant_s <= 1'b0;
      r_sp           <= SP_RST;
      r_s_op         <= 2'b00;
      r_s_wdata      <= 32'd0;
      r_p_we         <= 1'b0;
      r_p_addr       <= 32'd0;
      r_p_wdata      <= 16'd0;
      r_p_ack        <= 1'b0;
      r_p_rdata      <= 16'd0;
      r_s_ack        <= 1'b0;
      r_s_err        <= 1'b0;
      r_s_rdata      <= 32'd0;
      r_pop_lo       <= 16'd0;
    end else begin
      r_p_ack <= 1'b0;
      r_s_ack <= 1'b0;
      r_s_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_s) begin
            r_last_grant_s <= 1'b1;
            if (w_s_bad) begin
              // rejected without touching memory or sp
              r_s_ack <= 1'b1;
              r_s_err <= 1'b1;
            end else begin
              r_s_op    <= i_s_op;
              r_s_wdata <= i_s_wdata;
              r_state   <= S_W0;
            end
          end else if (w_grant_p) begin
            r_last_grant_s <= 1'b0;
            r_p_we         <= i_p_we;
            r_p_addr       <= i_p_addr;
            r_p_wdata      <= i_p_wdata;
            r_state        <= P_ACC;
          end
        end
        P_ACC: begin
          if (!r_p_we) begin
            r_p_rdata <= i_mem_rdata;
          end
          r_p_ack <= 1'b1;
          r_state <= IDLE;
        end
        S_W0: begin
          if (w_is_32) begin
            if (w_is_pop) begin
              r_pop_lo <= i_mem_rdata;
            end
            r_state <= S_W1;
          end else begin
            if (w_is_pop) begin
              r_s_rdata <= {16'd0, i_mem_rdata};
              r_sp      <= r_sp + 11'd1;
            end else begin
              r_sp <= r_sp - 11'd1;
            end
            r_s_ack <= 1'b1;
            r_state <= IDLE;
          end
        end
        S_W1: begin
          if (w_is_pop) begin
            r_s_rdata <= {i_mem_rdata, r_pop_lo};
            r_sp      <= r_sp + 11'd2;
          end else begin
            r_sp <= r_sp - 11'd2;
          end
          r_s_ack <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_p_ack   = r_p_ack;
  assign o_p_rdata = r_p_rdata;
  assign o_p_stall = i_p_req && !r_p_ack;
  assign o_s_ack   = r_s_ack;
  assign o_s_err   = r_s_err;
  assign o_s_rdata = r_s_rdata;
  assign o_sp      = r_sp;

endmodule
